disp_mux_nch: RTL and testbench
===============================

# disp_mux_nch

Parametrised N-channel display multiplexer for the seven-segment/LED display path of the pipelined CPU board. It selects one of `NCH` data channels, together with that channel's per-digit decimal-point and blink masks, for the display driver. Channel 0 is a CPU-owned register written with byte enables. Optionally, an auto-scan mode steps through the channels at a fixed dwell interval. All outputs are registered.

## Interface
Parameters:
- `NCH`, 8: channel count; power of two, 2..16.
- `DW`, 32: channel data width; multiple of 8.
- `PW`, `DW/4`: digits per channel; width of the point and blink masks.
- `DWELL`, 2**24: clock cycles per channel in auto-scan mode; ≥2.
- `RST_DATA`, 32'hAA5555AA: reset value of the channel-0 data register, truncated or zero-extended to `DW`.

Ports:
- `clk`: in, 1, clock.
- `rst`: in, 1, reset. Asynchronous, active-high.
- `we`: in, `DW/8`, byte write enables for the channel-0 register.
- `wdata`: in, `DW`, write data for channel 0.
- `wpoint`: in, `PW`, write data for the channel-0 point mask.
- `wblink`: in, `PW`, write data for the channel-0 blink mask.
- `sel`: in, `$clog2(NCH)`, manual channel select.
- `auto_en`: in, 1, 1 = auto-scan mode.
- `hold`: in, 1, freezes auto-scan stepping.
- `ch_data`: in, `NCH*DW`, channel data. Channel k occupies slice `[k*DW +: DW]`. Slice 0 is ignored.
- `ch_point`: in, `NCH*PW`, per-channel point masks, packed the same way as `ch_data`.
- `ch_blink`: in, `NCH*PW`, per-channel blink masks, packed the same way as `ch_data`.
- `disp_num`: out, `DW`, selected channel data.
- `point_out`: out, `PW`, selected point mask.
- `blink_out`: out, `PW`, selected blink mask.
- `cur_ch`: out, `$clog2(NCH)`, index of the channel currently shown.

## Operation
- Channel-0 register:
  - Reset values: data = `RST_DATA`, blink = all 1s, point = all 0s.
  - On a clock edge with `we[b]`=1: data byte b ← `wdata[8b+7:8b]`, point bits `[2b+1:2b]` ← the same bits of `wpoint`, blink bits `[2b+1:2b]` ← the same bits of `wblink`.
  - Bytes with `we[b]`=0 hold their value. Any combination of enables is legal.
- Channel source: index 0 reads the channel-0 register; index k≥1 reads slice k of `ch_data`, `ch_point` and `ch_blink`.
- Mode FSM, states MANUAL and AUTO:
  - MANUAL → AUTO when `auto_en`=1. On entry, the scan index is loaded from `sel` and the dwell counter is cleared.
  - AUTO → MANUAL when `auto_en`=0. From then on the scan index follows `sel`.
  - In AUTO with `hold`=0: the dwell counter counts 0..DWELL-1. At terminal count it wraps to 0 and the scan index increments, wrapping from NCH-1 to 0.
  - `hold`=1 freezes both the dwell counter and the scan index. `hold` has no effect in MANUAL.
- Output register: each edge, `disp_num`, `point_out` and `blink_out` ← the source selected by the scan index, and `cur_ch` ← the scan index.
- Reset (asynchronous, including mid-scan):
  - State MANUAL; dwell counter 0; scan index 0; channel-0 register at reset values.
  - `disp_num` = `RST_DATA`, `point_out` = 0, `blink_out` = all 1s, `cur_ch` = 0.

## Timing
- `sel` change at edge N (MANUAL): outputs show the new channel after edge N+1.
- Write to channel 0 at edge N: the register updates at N. If channel 0 is shown, `disp_num` reflects the write after edge N+1. A write and a display of channel 0 in the same cycle show the old value for that cycle.
- `ch_data` for k≥1 is sampled with one cycle of latency. No input synchronisation is done here.
- Auto-scan: each channel is shown for exactly `DWELL` cycles. `cur_ch` advances one cycle after the counter's terminal count.
- `auto_en` rising at edge N: the index = `sel` at N, and the first step occurs `DWELL` edges later.
- `auto_en` falling: `cur_ch` = `sel` after the next edge.
- Dwell counter width: `$clog2(DWELL)`. The index increment is modulo NCH, which is natural wrap because NCH is a power of two.

## Structure
- Shared package `disp_pkg`:
  - Reset constants: default `RST_DATA`, blink reset all 1s, point reset all 0s.
  - Mode state enum `{MANUAL, AUTO}`.
- Sub-module `disp_scan_timer`: holds the dwell counter, scan index and mode FSM. Inputs: `auto_en`, `hold`, `sel`. Outputs: the scan index.
- The top level holds the channel-0 byte-enabled register, the source mux and the output register.

## Test plan
All scenarios use `NCH`=8, `DW`=32, `DWELL`=4.
1. Reset released, `sel`=0 → `disp_num`=AA5555AA, `blink_out`=FF, `point_out`=00, `cur_ch`=0.
2. `we`=4'b0101, `wdata`=12345678, `wpoint`=FF, `sel`=0 → `disp_num`=AA3455 78, written as AA345578; `point_out`=33.
3. Channel 5 slice = DEADBEEF, `sel` 0→5 at edge N → `disp_num`=DEADBEEF and `cur_ch`=5 after edge N+1. No change at N.
4. `auto_en`=1 with `sel`=6 → `cur_ch` sequence 6,7,0,1, 4 cycles each. Assert `hold` for 10 cycles mid-dwell → the dwell is extended by exactly 10 cycles.
5. `auto_en` 1→0 while `cur_ch`=3, `sel`=1 → `cur_ch`=1 one edge later and stays there.
6. Assert `rst` mid-scan with `cur_ch`=5 and channel 0 written → all outputs return to the scenario-1 values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared constants and types for the display multiplexer path.
// Reset values of the CPU-owned channel-0 register and the scan mode encoding.
package disp_pkg;

    localparam logic [31:0] DEF_RST_DATA  = 32'hAA5555AA;
    localparam logic        BLINK_RST_BIT = 1'b1;
    localparam logic        POINT_RST_BIT = 1'b0;

    typedef enum logic {
        MANUAL = 1'b0,
        AUTO   = 1'b1
    } disp_mode_e;

endpackage

// File: rtl/disp_scan_timer.sv
// Mode FSM, dwell counter and scan index for the display multiplexer.
// In MANUAL the scan index follows sel directly; in AUTO it steps every DWELL cycles.
module disp_scan_timer
    import disp_pkg::*;
#(
    parameter int NCH   = 8,
    parameter int DWELL = 2**24,
    parameter int SW    = $clog2(NCH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          auto_en,
    input  logic          hold,
    input  logic [SW-1:0] sel,
    output logic [SW-1:0] scan_idx
);

    localparam int            CW       = $clog2(DWELL);
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

    disp_mode_e    state_q, state_d;
    logic [SW-1:0] idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        case (state_q)
            MANUAL: begin
                // Tracking sel here makes the AUTO entry load sel at the same edge.
                idx_d = sel;
                if (auto_en) begin
                    state_d = AUTO;
                    cnt_d   = '0;
                end
            end
            AUTO: begin
                if (!auto_en) begin
                    state_d = MANUAL;
                    idx_d   = sel;
                end else if (!hold) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        idx_d = idx_q + 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = MANUAL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= MANUAL;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    // Dropping auto_en hands control back to sel without waiting for the FSM edge.
    assign scan_idx = (state_q == AUTO && auto_en) ? idx_q : sel;

endmodule

// File: rtl/disp_mux_nch.sv
// N-channel display multiplexer: byte-writable channel 0, per-channel point/blink
// masks, manual or auto-scan selection, and fully registered outputs.
module disp_mux_nch
    import disp_pkg::*;
#(
    parameter int          NCH      = 8,
    parameter int          DW       = 32,
    parameter int          PW       = DW / 4,
    parameter int          DWELL    = 2**24,
    parameter logic [31:0] RST_DATA = DEF_RST_DATA
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DW/8-1:0]        we,
    input  logic [DW-1:0]          wdata,
    input  logic [PW-1:0]          wpoint,
    input  logic [PW-1:0]          wblink,
    input  logic [$clog2(NCH)-1:0] sel,
    input  logic                   auto_en,
    input  logic                   hold,
    input  logic [NCH*DW-1:0]      ch_data,
    input  logic [NCH*PW-1:0]      ch_point,
    input  logic [NCH*PW-1:0]      ch_blink,
    output logic [DW-1:0]          disp_num,
    output logic [PW-1:0]          point_out,
    output logic [PW-1:0]          blink_out,
    output logic [$clog2(NCH)-1:0] cur_ch
);

    localparam int            SW        = $clog2(NCH);
    localparam int            NB        = DW / 8;
    localparam logic [DW-1:0] RST_DW    = DW'(RST_DATA);
    localparam logic [PW-1:0] RST_BLINK = {PW{BLINK_RST_BIT}};
    localparam logic [PW-1:0] RST_POINT = {PW{POINT_RST_BIT}};

    logic [SW-1:0] scan_idx;

    logic [DW-1:0] c0_data_q, c0_data_d;
    logic [PW-1:0] c0_point_q, c0_point_d;
    logic [PW-1:0] c0_blink_q, c0_blink_d;

    logic [DW-1:0] src_data;
    logic [PW-1:0] src_point, src_blink;

    logic [DW-1:0] disp_num_q, disp_num_d;
    logic [PW-1:0] point_out_q, point_out_d;
    logic [PW-1:0] blink_out_q, blink_out_d;
    logic [SW-1:0] cur_ch_q, cur_ch_d;

    disp_scan_timer #(
        .NCH   (NCH),
        .DWELL (DWELL),
        .SW    (SW)
    ) u_scan_timer (
        .clk      (clk),
        .rst      (rst),
        .auto_en  (auto_en),
        .hold     (hold),
        .sel      (sel),
        .scan_idx (scan_idx)
    );

    // Each data byte owns two digits, hence two point and two blink bits.
    always_comb begin
        c0_data_d  = c0_data_q;
        c0_point_d = c0_point_q;
        c0_blink_d = c0_blink_q;
        for (int b = 0; b < NB; b++) begin
            if (we[b]) begin
                c0_data_d[8*b +: 8]  = wdata[8*b +: 8];
                c0_point_d[2*b +: 2] = wpoint[2*b +: 2];
                c0_blink_d[2*b +: 2] = wblink[2*b +: 2];
            end
        end
    end

    always_comb begin
        src_data  = c0_data_q;
        src_point = c0_point_q;
        src_blink = c0_blink_q;
        if (scan_idx != '0) begin
            src_data  = ch_data[int'(scan_idx)*DW +: DW];
            src_point = ch_point[int'(scan_idx)*PW +: PW];
            src_blink = ch_blink[int'(scan_idx)*PW +: PW];
        end
    end

    always_comb begin
        disp_num_d  = src_data;
        point_out_d = src_point;
        blink_out_d = src_blink;
        cur_ch_d    = scan_idx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c0_data_q   <= RST_DW;
            c0_point_q  <= RST_POINT;
            c0_blink_q  <= RST_BLINK;
            disp_num_q  <= RST_DW;
            point_out_q <= RST_POINT;
            blink_out_q <= RST_BLINK;
            cur_ch_q    <= '0;
        end else begin
            c0_data_q   <= c0_data_d;
            c0_point_q  <= c0_point_d;
            c0_blink_q  <= c0_blink_d;
            disp_num_q  <= disp_num_d;
            point_out_q <= point_out_d;
            blink_out_q <= blink_out_d;
            cur_ch_q    <= cur_ch_d;
        end
    end

    assign disp_num  = disp_num_q;
    assign point_out = point_out_q;
    assign blink_out = blink_out_q;
    assign cur_ch    = cur_ch_q;

endmodule

// File: tb/tb_disp_mux_nch.sv
// Directed bench for disp_mux_nch with NCH=8, DW=32, DWELL=4.
// Table of manual-mode vectors plus hand-written auto-scan, hold and reset sequences.
module tb_disp_mux_nch;

    localparam int NCH   = 8;
    localparam int DW    = 32;
    localparam int PW    = 8;
    localparam int DWELL = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [3:0]        we;
    logic [DW-1:0]     wdata;
    logic [PW-1:0]     wpoint;
    logic [PW-1:0]     wblink;
    logic [2:0]        sel;
    logic              auto_en;
    logic              hold;
    logic [NCH*DW-1:0] ch_data;
    logic [NCH*PW-1:0] ch_point;
    logic [NCH*PW-1:0] ch_blink;
    logic [DW-1:0]     disp_num;
    logic [PW-1:0]     point_out;
    logic [PW-1:0]     blink_out;
    logic [2:0]        cur_ch;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [2:0]  sel;
        logic [3:0]  we;
        logic [31:0] wdata;
        logic [7:0]  wpoint;
        logic [7:0]  wblink;
        logic [31:0] exp_data;
        logic [7:0]  exp_point;
        logic [7:0]  exp_blink;
        logic [2:0]  exp_ch;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    disp_mux_nch #(
        .NCH   (NCH),
        .DW    (DW),
        .DWELL (DWELL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .we        (we),
        .wdata     (wdata),
        .wpoint    (wpoint),
        .wblink    (wblink),
        .sel       (sel),
        .auto_en   (auto_en),
        .hold      (hold),
        .ch_data   (ch_data),
        .ch_point  (ch_point),
        .ch_blink  (ch_blink),
        .disp_num  (disp_num),
        .point_out (point_out),
        .blink_out (blink_out),
        .cur_ch    (cur_ch)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check_all(input string name, input logic [31:0] ed, input logic [7:0] ep,
                             input logic [7:0] eb, input logic [2:0] ec);
        check({name, " disp_num"}, disp_num, ed);
        check({name, " point_out"}, 32'(point_out), 32'(ep));
        check({name, " blink_out"}, 32'(blink_out), 32'(eb));
        check({name, " cur_ch"}, 32'(cur_ch), 32'(ec));
    endtask

    initial begin
        int n;
        int guard;
        logic [2:0] exp_seq[12];

        rst      = 1'b1;
        we       = '0;
        wdata    = '0;
        wpoint   = '0;
        wblink   = '0;
        sel      = '0;
        auto_en  = 1'b0;
        hold     = 1'b0;
        ch_data  = {32'h7777_0007, 32'h6666_0006, 32'hDEAD_BEEF, 32'h4444_0004,
                    32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'hFFFF_FFFF};
        ch_point = {8'h70, 8'h60, 8'h50, 8'h40, 8'h30, 8'h20, 8'h10, 8'hEE};
        ch_blink = {8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'hDD};

        vecs[0] = '{3'd0, 4'b1000, 32'h9900_0000, 8'hC0, 8'h40, 32'h9934_5578, 8'hF3, 8'h4C, 3'd0};
        vecs[1] = '{3'd3, 4'b0000, 32'h0000_0000, 8'h00, 8'h00, 32'h3333_0003, 8'h30, 8'h03, 3'd3};
        vecs[2] = '{3'd7, 4'b0000, 32'h0000_0000, 8'h00, 8'h00, 32'h7777_0007, 8'h70, 8'h07, 3'd7};
        vecs[3] = '{3'd1, 4'b0000, 32'h0000_0000, 8'h00, 8'h00, 32'h1111_0001, 8'h10, 8'h01, 3'd1};
        vecs[4] = '{3'd0, 4'b0010, 32'h0000_AB00, 8'h0C, 8'h00, 32'h9934_AB78, 8'hFF, 8'h40, 3'd0};
        vecs[5] = '{3'd2, 4'b0000, 32'h0000_0000, 8'h00, 8'h00, 32'h2222_0002, 8'h20, 8'h02, 3'd2};
        vecs[6] = '{3'd0, 4'b1111, 32'h0123_4567, 8'h5A, 8'hA5, 32'h0123_4567, 8'h5A, 8'hA5, 3'd0};
        vecs[7] = '{3'd0, 4'b0000, 32'hFFFF_FFFF, 8'hFF, 8'hFF, 32'h0123_4567, 8'h5A, 8'hA5, 3'd0};

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_all("reset", 32'hAA55_55AA, 8'h00, 8'hFF, 3'd0);
        tick();
        check_all("reset_hold", 32'hAA55_55AA, 8'h00, 8'hFF, 3'd0);

        // Byte-enabled write, old value visible for the write cycle
        we     = 4'b0101;
        wdata  = 32'h1234_5678;
        wpoint = 8'hFF;
        wblink = 8'h00;
        tick();
        we = '0;
        check("wr_old_value", disp_num, 32'hAA55_55AA);
        tick();
        check_all("wr_bytes", 32'hAA34_5578, 8'h33, 8'hCC, 3'd0);

        // Manual select latency
        sel = 3'd5;
        #1;
        check("sel_no_comb", disp_num, 32'hAA34_5578);
        tick();
        check_all("sel5", 32'hDEAD_BEEF, 8'h50, 8'h05, 3'd5);

        for (int i = 0; i < 8; i++) begin
            sel    = vecs[i].sel;
            we     = vecs[i].we;
            wdata  = vecs[i].wdata;
            wpoint = vecs[i].wpoint;
            wblink = vecs[i].wblink;
            tick();
            we = '0;
            tick();
            check_all($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_point,
                      vecs[i].exp_blink, vecs[i].exp_ch);
        end

        // Auto-scan from sel=6: 4 cycles per channel
        sel = 3'd6;
        tick();
        auto_en = 1'b1;
        tick();
        check("auto_entry", 32'(cur_ch), 32'd6);
        exp_seq = '{3'd6, 3'd6, 3'd6, 3'd6, 3'd7, 3'd7, 3'd7, 3'd7, 3'd0, 3'd0, 3'd0, 3'd0};
        for (int i = 0; i < 12; i++) begin
            tick();
            check($sformatf("auto_seq%0d", i), 32'(cur_ch), 32'(exp_seq[i]));
        end
        tick();
        check("auto_ch1", 32'(cur_ch), 32'd1);
        check("auto_ch1_data", disp_num, 32'h1111_0001);

        // Hold for 10 cycles mid-dwell stretches channel 1 to 14 cycles
        n = 1;
        hold = 1'b1;
        repeat (10) begin
            tick();
            if (cur_ch == 3'd1) n++;
        end
        hold = 1'b0;
        guard = 0;
        while (guard < 40) begin
            tick();
            guard++;
            if (cur_ch == 3'd1) n++;
            else break;
        end
        check("hold_dwell_len", 32'(n), 32'd14);
        check("after_hold_ch", 32'(cur_ch), 32'd2);

        // Leave auto mode while channel 3 is shown
        guard = 0;
        while (cur_ch != 3'd3 && guard < 20) begin
            tick();
            guard++;
        end
        check("reach_ch3", 32'(cur_ch), 32'd3);
        sel     = 3'd1;
        auto_en = 1'b0;
        tick();
        check("manual_back", 32'(cur_ch), 32'd1);
        check("manual_back_data", disp_num, 32'h1111_0001);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("manual_stay%0d", i), 32'(cur_ch), 32'd1);
        end

        // Asynchronous reset mid-scan with channel 0 modified
        we     = 4'b1111;
        wdata  = 32'hCAFE_F00D;
        wpoint = 8'h00;
        wblink = 8'h00;
        tick();
        we      = '0;
        sel     = 3'd5;
        auto_en = 1'b1;
        tick();
        check("pre_rst_ch", 32'(cur_ch), 32'd5);
        #2;
        rst = 1'b1;
        #1;
        check_all("async_rst", 32'hAA55_55AA, 8'h00, 8'hFF, 3'd0);
        tick();
        rst     = 1'b0;
        auto_en = 1'b0;
        sel     = 3'd0;
        tick();
        check_all("post_rst_ch0", 32'hAA55_55AA, 8'h00, 8'hFF, 3'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
